// File: rtl/pipeline_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Central stall/flush controller for a 5-stage (IF/ID/EX/MEM/WB) pipeline.
//   - RAW hazard detection between ID sources and EX/MEM destinations
//     (combinational, produces freeze_front / bubble_id).
//   - Multi-cycle memory sequencing: freezes the whole pipe for
//     MEM_LATENCY-1 cycles, then gives one release cycle.
//   - Taken-branch flush, deferred across memory freezes.
// Output priority: freeze_all > flush > hazard.
//
// Optional build macro: FORWARDING_EN
//   defined   : only load-use hazards stall (EX/MEM forwarding exists).
//   undefined : full RAW stall against EX and MEM destinations.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   id_valid, id_src1/2,     ID stage instruction and its source registers
//   id_two_src
//   ex_dest, ex_wb_en,       EX stage destination, writeback, load flag
//   ex_mem_r_en
//   mem_dest, mem_wb_en      MEM stage destination and writeback
//   mem_access               MEM stage holds a load/store (level)
//   branch_taken             one-cycle pulse, branch resolved taken in EX
//   freeze_front             hold PC and IF stage register
//   bubble_id                ID stage register loads a NOP
//   flush                    clear IF/ID registers, PC takes branch target
//   freeze_all               hold every stage register and the PC
//   ctrl_state               current FSM state (debug)
// ----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
  parameter int unsigned REG_ADDR_W  = 4,
  parameter int unsigned MEM_LATENCY = 6,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_src1,
  input  logic [REG_ADDR_W-1:0] id_src2,
  input  logic                  id_two_src,
  input  logic [REG_ADDR_W-1:0] ex_dest,
  input  logic                  ex_wb_en,
  input  logic                  ex_mem_r_en,
  input  logic [REG_ADDR_W-1:0] mem_dest,
  input  logic                  mem_wb_en,
  input  logic                  mem_access,
  input  logic                  branch_taken,
  output logic                  freeze_front,
  output logic                  bubble_id,
  output logic                  flush,
  output logic                  freeze_all,
  output logic [1:0]            ctrl_state
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1
  } state_e;

  // A one-cycle access never needs to freeze, so the FSM stays in RUN.
  localparam logic             LONG_ACCESS = (MEM_LATENCY > 32'd1);
  localparam logic [CNT_W-1:0] CNT_LOAD    =
    CNT_W'(LONG_ACCESS ? (MEM_LATENCY - 32'd2) : 32'd0);

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_branch_pend;

  logic w_freeze_raw;
  logic w_hz_raw;
  logic w_hz;

  // Freeze request from the memory sequencer; the first frozen cycle is the
  // RUN cycle in which the access shows up.
  always_comb begin
    w_freeze_raw = 1'b0;
    case (r_state)
      RUN:      w_freeze_raw = LONG_ACCESS & mem_access;
      MEM_WAIT: w_freeze_raw = (r_cnt != '0);
      default:  w_freeze_raw = 1'b0;
    endcase
  end

  // RAW hazard between ID sources and in-flight destinations.
`ifdef FORWARDING_EN
  assign w_hz_raw = id_valid & ex_mem_r_en & ex_wb_en &
                    ((ex_dest == id_src1) | (id_two_src & (ex_dest == id_src2)));

  logic w_unused_mem;
  assign w_unused_mem = &{1'b0, mem_dest, mem_wb_en};
`else
  assign w_hz_raw = id_valid & (
                      (ex_wb_en  & (ex_dest  == id_src1)) |
                      (mem_wb_en & (mem_dest == id_src1)) |
                      (id_two_src & ((ex_wb_en  & (ex_dest  == id_src2)) |
                                     (mem_wb_en & (mem_dest == id_src2)))));

  logic w_unused_load;
  assign w_unused_load = &{1'b0, ex_mem_r_en};
`endif

  // Every output is held low while reset is asserted, whatever the inputs.
  assign freeze_all   = rst & w_freeze_raw;
  assign flush        = rst & (branch_taken | r_branch_pend) & ~freeze_all;
  assign w_hz         = rst & w_hz_raw;
  assign freeze_front = freeze_all | (w_hz & ~flush);
  assign bubble_id    = w_hz & ~flush & ~freeze_all;
  assign ctrl_state   = r_state;

  // Memory-wait FSM, wait counter and deferred-branch flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= RUN;
      r_cnt         <= '0;
      r_branch_pend <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (LONG_ACCESS && mem_access) begin
            r_state <= MEM_WAIT;
            r_cnt   <= CNT_LOAD;
          end
        end
        MEM_WAIT: begin
          // mem_access is ignored here: it is the same instruction.
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else begin
            r_state <= RUN;
          end
        end
        default: begin
          r_state <= RUN;
          r_cnt   <= '0;
        end
      endcase

      // A branch seen while frozen is remembered; extra branches while
      // pending collapse into the single flush.
      if (flush) begin
        r_branch_pend <= 1'b0;
      end else if (branch_taken && freeze_all) begin
        r_branch_pend <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
// Directed scenarios followed by randomized traffic, every cycle compared
// against a cycle-indexed behavioural model of the controller.
// ----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

  localparam int unsigned RW  = 4;
  localparam int          LAT = 6;

  logic          clk;
  logic          rst;
  logic          id_valid;
  logic [RW-1:0] id_src1;
  logic [RW-1:0] id_src2;
  logic          id_two_src;
  logic [RW-1:0] ex_dest;
  logic          ex_wb_en;
  logic          ex_mem_r_en;
  logic [RW-1:0] mem_dest;
  logic          mem_wb_en;
  logic          mem_access;
  logic          branch_taken;
  logic          freeze_front;
  logic          bubble_id;
  logic          flush;
  logic          freeze_all;
  logic [1:0]    ctrl_state;

  int n_cmp;
  int n_err;

  // Model state: the cycle index at which the current memory window began.
  int cyc;
  int win_start;
  bit win_valid;
  bit pend;

  // Observations used by directed scenarios.
  int fz_seen;
  int fl_seen;

  pipeline_hazard_ctrl #(
    .REG_ADDR_W (RW),
    .MEM_LATENCY(LAT),
    .CNT_W      (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_src1     (id_src1),
    .id_src2     (id_src2),
    .id_two_src  (id_two_src),
    .ex_dest     (ex_dest),
    .ex_wb_en    (ex_wb_en),
    .ex_mem_r_en (ex_mem_r_en),
    .mem_dest    (mem_dest),
    .mem_wb_en   (mem_wb_en),
    .mem_access  (mem_access),
    .branch_taken(branch_taken),
    .freeze_front(freeze_front),
    .bubble_id   (bubble_id),
    .flush       (flush),
    .freeze_all  (freeze_all),
    .ctrl_state  (ctrl_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  // Hazard from the rule: does any ID source name a register being written?
  function automatic bit model_hz();
    logic [RW-1:0] srcs[$];
    logic [RW-1:0] dsts[$];
    bit hit;
    if (!id_valid) return 1'b0;
`ifdef FORWARDING_EN
    if (!(ex_mem_r_en && ex_wb_en)) return 1'b0;
    dsts.push_back(ex_dest);
`else
    if (ex_wb_en)  dsts.push_back(ex_dest);
    if (mem_wb_en) dsts.push_back(mem_dest);
`endif
    srcs.push_back(id_src1);
    if (id_two_src) srcs.push_back(id_src2);
    hit = 1'b0;
    foreach (srcs[i]) foreach (dsts[j]) if (srcs[i] == dsts[j]) hit = 1'b1;
    return hit;
  endfunction

  task automatic model_reset();
    win_valid = 1'b0;
    win_start = 0;
    pend      = 1'b0;
  endtask

  // Evaluate one cycle mid-period: compare outputs, then advance the model.
  task automatic eval();
    int off;
    bit fz, fl, hz, ff, bub;
    int st;
    @(negedge clk);
    if (!rst) begin
      model_reset();
      fz = 0; fl = 0; ff = 0; bub = 0; st = 0;
    end else begin
      off = cyc - win_start;
      if (win_valid && off >= LAT) win_valid = 1'b0;
      if (!win_valid && mem_access && LAT > 1) begin
        win_valid = 1'b1;
        win_start = cyc;
        off       = 0;
      end
      fz  = win_valid && (off < LAT - 1);
      st  = (win_valid && off >= 1) ? 1 : 0;
      hz  = model_hz();
      fl  = (branch_taken || pend) && !fz;
      ff  = fz || (hz && !fl);
      bub = hz && !fl && !fz;
      if (fl) pend = 1'b0;
      else if (branch_taken && fz) pend = 1'b1;
    end
    check("freeze_all",   8'(freeze_all),   8'(fz));
    check("flush",        8'(flush),        8'(fl));
    check("freeze_front", 8'(freeze_front), 8'(ff));
    check("bubble_id",    8'(bubble_id),    8'(bub));
    check("ctrl_state",   8'(ctrl_state),   8'(st));
    if (freeze_all) fz_seen++;
    if (flush)      fl_seen++;
    cyc++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    id_valid = 0; id_src1 = 0; id_src2 = 0; id_two_src = 0;
    ex_dest = 0; ex_wb_en = 0; ex_mem_r_en = 0;
    mem_dest = 0; mem_wb_en = 0; mem_access = 0; branch_taken = 0;
  endtask

  task automatic randomize_inputs();
    id_valid     = ($urandom_range(0, 3) != 0);
    id_src1      = RW'($urandom_range(0, 3));
    id_src2      = RW'($urandom_range(0, 3));
    id_two_src   = 1'($urandom);
    ex_dest      = RW'($urandom_range(0, 3));
    ex_wb_en     = 1'($urandom);
    ex_mem_r_en  = 1'($urandom);
    mem_dest     = RW'($urandom_range(0, 3));
    mem_wb_en    = 1'($urandom);
    mem_access   = ($urandom_range(0, 5) == 0);
    branch_taken = ($urandom_range(0, 4) == 0);
  endtask

  initial begin
    n_cmp = 0; n_err = 0; cyc = 0; fz_seen = 0; fl_seen = 0;
    model_reset();
    quiet();

    // Reset dominates active inputs.
    rst = 1'b0;
    mem_access = 1; branch_taken = 1;
    id_valid = 1; id_src1 = 3; ex_dest = 3; ex_wb_en = 1; ex_mem_r_en = 1;
    repeat (3) eval();
    tick(); rst = 1'b1; quiet(); eval();
    check("rst_state", 8'(ctrl_state), 8'd0);

    // Single access: LAT-1 frozen cycles, then release.
    fz_seen = 0;
    tick(); mem_access = 1; eval();
    tick(); mem_access = 0;
    repeat (LAT + 1) begin eval(); tick(); end
    check("fz_len", 8'(fz_seen), 8'(LAT - 1));

    // Back-to-back: held access restarts right after each release.
    fz_seen = 0;
    mem_access = 1;
    repeat (2 * LAT) begin eval(); tick(); end
    mem_access = 0;
    repeat (LAT) begin eval(); tick(); end
    check("fz_b2b", 8'(fz_seen), 8'(2 * (LAT - 1)));

    // RAW against EX, without and with the load flag.
    quiet(); id_valid = 1; id_src1 = 3; ex_dest = 3; ex_wb_en = 1; eval();
    tick(); ex_mem_r_en = 1; eval();
    tick(); ex_mem_r_en = 0; mem_dest = 5; mem_wb_en = 1; id_src1 = 5; eval();

    // Branch wins over hazard.
    tick(); quiet(); id_valid = 1; id_src1 = 2; ex_dest = 2; ex_wb_en = 1;
    ex_mem_r_en = 1; branch_taken = 1; eval();
    check("br_vs_hz_flush", 8'(flush), 8'd1);

    // Branch during the 3rd frozen cycle is deferred to the release cycle.
    tick(); quiet(); fl_seen = 0;
    tick(); mem_access = 1; eval();
    tick(); mem_access = 0; eval();
    tick(); branch_taken = 1; eval();
    tick(); branch_taken = 0; eval();
    tick(); branch_taken = 1; eval();
    repeat (LAT) begin tick(); branch_taken = 0; eval(); end
    check("deferred_flush_cnt", 8'(fl_seen), 8'd1);

    // Reset in the middle of a wait with a branch pending drops both.
    tick(); quiet(); fl_seen = 0;
    tick(); mem_access = 1; eval();
    tick(); mem_access = 0; branch_taken = 1; eval();
    tick(); branch_taken = 0; eval();
    tick(); rst = 0; eval();
    tick(); rst = 1; eval();
    check("rst_wait_state", 8'(ctrl_state), 8'd0);
    repeat (LAT) begin tick(); eval(); end
    check("rst_wait_flush_cnt", 8'(fl_seen), 8'd0);

    // Randomized traffic with occasional asynchronous resets.
    repeat (3000) begin
      tick();
      randomize_inputs();
      if (!rst) rst = 1'b1;
      else if ($urandom_range(0, 149) == 0) rst = 1'b0;
      eval();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
